// File: rtl/crossbar3_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : crossbar3_arbiter_if
//  Description : Handshake, destination and select bundle for the 3x3
//                security-domain crossbar arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface crossbar3_arbiter_if;
    logic       in0_val,    in1_val,    in2_val;
    logic       in0_rdy,    in1_rdy,    in2_rdy;
    logic [1:0] in0_dest,   in1_dest,   in2_dest;
    logic       in0_last,   in1_last,   in2_last;
    logic       in0_domain, in1_domain, in2_domain;
    logic       out0_val,   out1_val,   out2_val;
    logic       out0_rdy,   out1_rdy,   out2_rdy;
    logic [1:0] sel0,       sel1,       sel2;
    logic       out0_scrub, out1_scrub, out2_scrub;
    logic       err_domain;

    modport slave (
        input  in0_val, in1_val, in2_val,
        input  in0_dest, in1_dest, in2_dest,
        input  in0_last, in1_last, in2_last,
        input  in0_domain, in1_domain, in2_domain,
        input  out0_rdy, out1_rdy, out2_rdy,
        output in0_rdy, in1_rdy, in2_rdy,
        output out0_val, out1_val, out2_val,
        output sel0, sel1, sel2,
        output out0_scrub, out1_scrub, out2_scrub,
        output err_domain
    );

    modport master (
        output in0_val, in1_val, in2_val,
        output in0_dest, in1_dest, in2_dest,
        output in0_last, in1_last, in2_last,
        output in0_domain, in1_domain, in2_domain,
        output out0_rdy, out1_rdy, out2_rdy,
        input  in0_rdy, in1_rdy, in2_rdy,
        input  out0_val, out1_val, out2_val,
        input  sel0, sel1, sel2,
        input  out0_scrub, out1_scrub, out2_scrub,
        input  err_domain
    );
endinterface
`default_nettype wire

// File: rtl/crossbar3_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : crossbar3_arbiter
//  Description : Per-output round-robin arbiter with message locking for the
//                3x3 crossbar. CROSSBAR3_ARB_SCRUB_EN adds a scrub cycle on
//                every change of security domain at an output.
//  Revision    : 1.0  initial release
// ============================================================================
module crossbar3_arbiter (
    input  wire logic          clk,
    input  wire logic          reset_n,
    crossbar3_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1
    } state_t;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    logic [2:0] w_in_val, w_in_last, w_in_dom, w_out_rdy;
    logic [2:0] w_out_val, w_out_scrub, w_dom_err, w_in_rdy;
    logic [1:0] w_in_dest [3];
    logic [2:0] w_grant   [3];
    logic [1:0] w_sel     [3];
    logic       r_err_domain;

    assign w_in_val     = {bus.in2_val,    bus.in1_val,    bus.in0_val};
    assign w_in_last    = {bus.in2_last,   bus.in1_last,   bus.in0_last};
    assign w_in_dom     = {bus.in2_domain, bus.in1_domain, bus.in0_domain};
    assign w_out_rdy    = {bus.out2_rdy,   bus.out1_rdy,   bus.out0_rdy};
    assign w_in_dest[0] = bus.in0_dest;
    assign w_in_dest[1] = bus.in1_dest;
    assign w_in_dest[2] = bus.in2_dest;

    for (genvar k = 0; k < 3; k++) begin : g_out
        localparam logic [1:0] c_port = 2'(k);

        state_t     r_state;
        logic [1:0] r_owner, r_ptr;
        logic       r_last_dom, r_dom_vld;
        logic [2:0] w_cand, w_gnt;
        logic [1:0] w_p1, w_p2, w_win, w_sel_k;
        logic       w_val, w_scrub, w_err, w_fire;

        always_comb begin
            w_cand = '0;
            for (int i = 0; i < 3; i++)
                w_cand[i] = w_in_val[i] && (w_in_dest[i] == c_port);
        end

        // Lowest-rank candidate in the rotation ptr, ptr+1, ptr+2 wins.
        assign w_p1 = inc3(r_ptr);
        assign w_p2 = inc3(w_p1);
        always_comb begin
            w_win = r_ptr;
            if (w_cand[w_p2])  w_win = w_p2;
            if (w_cand[w_p1])  w_win = w_p1;
            if (w_cand[r_ptr]) w_win = r_ptr;
        end

        // Reset also gates the combinational grant so outputs drop at once.
        always_comb begin
            w_gnt   = '0;
            w_val   = 1'b0;
            w_sel_k = r_owner;
            w_scrub = 1'b0;
            w_err   = 1'b0;
            if (reset_n) begin
                case (r_state)
                    ST_IDLE: begin
                        if (|w_cand) begin
`ifdef CROSSBAR3_ARB_SCRUB_EN
                            // The cycle that first sees the domain change is
                            // the scrub cycle, so a change costs one cycle.
                            if (r_dom_vld && (w_in_dom[w_win] != r_last_dom)) begin
                                w_scrub = 1'b1;
                            end else begin
                                w_gnt[w_win] = 1'b1;
                                w_val        = 1'b1;
                                w_sel_k      = w_win;
                            end
`else
                            w_gnt[w_win] = 1'b1;
                            w_val        = 1'b1;
                            w_sel_k      = w_win;
`endif
                        end
                    end
                    ST_LOCKED: begin
                        if (w_in_val[r_owner] && (w_in_dest[r_owner] == c_port)) begin
                            if (!r_dom_vld || (w_in_dom[r_owner] == r_last_dom)) begin
                                w_gnt[r_owner] = 1'b1;
                                w_val          = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign w_fire = w_val && w_out_rdy[k];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state    <= ST_IDLE;
                r_owner    <= 2'd0;
                r_ptr      <= 2'd0;
                r_last_dom <= 1'b0;
                r_dom_vld  <= 1'b0;
            end else begin
                if (w_fire) begin
                    r_last_dom <= w_in_dom[w_sel_k];
                    r_dom_vld  <= 1'b1;
                end
`ifdef CROSSBAR3_ARB_SCRUB_EN
                // Forget the old domain so the next arbitration goes through.
                if (w_scrub)
                    r_dom_vld <= 1'b0;
`endif
                case (r_state)
                    ST_IDLE: begin
                        if (w_fire) begin
                            if (w_in_last[w_win]) begin
                                r_ptr <= inc3(w_win);
                            end else begin
                                r_state <= ST_LOCKED;
                                r_owner <= w_win;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_fire && w_in_last[r_owner]) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= inc3(r_owner);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end

        assign w_grant[k]     = w_gnt;
        assign w_sel[k]       = w_sel_k;
        assign w_out_val[k]   = w_val;
        assign w_out_scrub[k] = w_scrub;
        assign w_dom_err[k]   = w_err;
    end

    always_comb begin
        w_in_rdy = '0;
        for (int k = 0; k < 3; k++)
            w_in_rdy = w_in_rdy | (w_grant[k] & {3{w_out_rdy[k]}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err_domain <= 1'b0;
        else if (|w_dom_err)
            r_err_domain <= 1'b1;
    end

    assign bus.in0_rdy    = w_in_rdy[0];
    assign bus.in1_rdy    = w_in_rdy[1];
    assign bus.in2_rdy    = w_in_rdy[2];
    assign bus.out0_val   = w_out_val[0];
    assign bus.out1_val   = w_out_val[1];
    assign bus.out2_val   = w_out_val[2];
    assign bus.sel0       = w_sel[0];
    assign bus.sel1       = w_sel[1];
    assign bus.sel2       = w_sel[2];
    assign bus.out0_scrub = w_out_scrub[0];
    assign bus.out1_scrub = w_out_scrub[1];
    assign bus.out2_scrub = w_out_scrub[2];
    assign bus.err_domain = r_err_domain;
endmodule
`default_nettype wire
